// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the multi-word sequential adder.
//   ADD_SLICE_W : width of one datapath slice (the adder core width)
//   state_t     : control FSM states
package multiword_add_seq_pkg;

  localparam int ADD_SLICE_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_add_seq_skl8cskip32.sv
// skl8cskip32: 32-bit carry-skip adder, eight 4-bit ripple blocks.
// A block whose bits all propagate forwards its incoming carry directly
// to the next block instead of waiting on its own ripple chain.
// Ports:
//   a_i, b_i : addends
//   ci_i     : carry in
//   s_o      : sum
//   co_o     : carry out of bit 31
module skl8cskip32
  import multiword_add_seq_pkg::*;
(
  input  logic [ADD_SLICE_W-1:0] a_i,
  input  logic [ADD_SLICE_W-1:0] b_i,
  input  logic                   ci_i,
  output logic [ADD_SLICE_W-1:0] s_o,
  output logic                   co_o
);

  localparam int BLK  = 4;
  localparam int NBLK = ADD_SLICE_W / BLK;

  for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK-1:0] s_blk;
    logic           cin_blk;
    logic           rip_co;
    logic           co_blk;

    if (gi == 0) begin : g_first
      assign cin_blk = ci_i;
    end else begin : g_chain
      assign cin_blk = g_blk[gi-1].co_blk;
    end

    assign p = a_i[gi*BLK +: BLK] ^ b_i[gi*BLK +: BLK];
    assign g = a_i[gi*BLK +: BLK] & b_i[gi*BLK +: BLK];

    // Ripple inside the block; the running carry is a local variable so
    // no combinational vector feeds back into itself.
    always_comb begin
      logic c;
      c     = cin_blk;
      s_blk = '0;
      for (int j = 0; j < BLK; j++) begin
        s_blk[j] = p[j] ^ c;
        c        = g[j] | (p[j] & c);
      end
      rip_co = c;
    end

    assign s_o[gi*BLK +: BLK] = s_blk;
    // Skip path: all-propagate block passes its carry-in straight through.
    assign co_blk = (&p) ? cin_blk : rip_co;
  end

  assign co_o = g_blk[NBLK-1].co_blk;

endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: adds/subtracts two WORDS*32-bit operands by streaming
// one 32-bit slice per cycle through a single skl8cskip32 instance.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (a, b, cin, sub)
//   out_valid/out_ready  : result handshake (sum, cout, ovf)
//   sum                  : WORDS*32-bit result, registered
//   cout                 : carry out of the top slice (borrow_n when sub=1)
//   ovf                  : signed overflow of the full-width result
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORDS*ADD_SLICE_W-1:0] a,
  input  logic [WORDS*ADD_SLICE_W-1:0] b,
  input  logic                         cin,
  input  logic                         sub,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORDS*ADD_SLICE_W-1:0] sum,
  output logic                         cout,
  output logic                         ovf
);

  localparam int W     = WORDS * ADD_SLICE_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t                 state_q, state_d;
  logic [W-1:0]           a_q, b_q;
  logic                   carry_q;
  logic [IDX_W-1:0]       idx_q;
  logic [ADD_SLICE_W-1:0] sum_q [WORDS];
  logic                   cout_q, ovf_q;

  logic [ADD_SLICE_W-1:0] a_words [WORDS];
  logic [ADD_SLICE_W-1:0] b_words [WORDS];
  logic [ADD_SLICE_W-1:0] slice_a, slice_b, slice_s;
  logic                   slice_co;
  logic                   accept;
  logic                   last;

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
    assign a_words[gi]                    = a_q[gi*ADD_SLICE_W +: ADD_SLICE_W];
    assign b_words[gi]                    = b_q[gi*ADD_SLICE_W +: ADD_SLICE_W];
    assign sum[gi*ADD_SLICE_W +: ADD_SLICE_W] = sum_q[gi];
  end

  assign slice_a = a_words[idx_q];
  assign slice_b = b_words[idx_q];
  assign last    = (idx_q == LAST_IDX);
  assign accept  = in_valid & in_ready;
  assign cout    = cout_q;
  assign ovf     = ovf_q;

  skl8cskip32 u_slice_add (
    .a_i  (slice_a),
    .b_i  (slice_b),
    .ci_i (carry_q),
    .s_o  (slice_s),
    .co_o (slice_co)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Result leaving this cycle frees the block for a new bundle now.
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < WORDS; i++) sum_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Subtraction is A + ~B + 1: invert B once here, force carry-in.
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub | cin;
        idx_q   <= '0;
      end else if (state_q == RUN) begin
        sum_q[idx_q] <= slice_s;
        carry_q      <= slice_co;
        if (last) begin
          cout_q <= slice_co;
          ovf_q  <= (a_q[W-1] == b_q[W-1]) && (slice_s[ADD_SLICE_W-1] != a_q[W-1]);
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
module tb_multiword_add_seq;
  localparam int WORDS = 4;
  localparam int W     = WORDS * 32;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf;

  logic         or_dir, or_rnd, rnd_mode;
  assign out_ready = rnd_mode ? or_rnd : or_dir;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Reference: plain wide arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] ma, mb, input logic mc, ms);
    exp_t r;
    logic [W:0] full;
    logic signed [W+1:0] sa, sb, sr;
    sa = $signed({{2{ma[W-1]}}, ma});
    sb = $signed({{2{mb[W-1]}}, mb});
    if (ms) begin
      r.s = ma - mb;
      r.c = (ma >= mb);
      sr  = sa - sb;
    end else begin
      full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
      r.s  = full[W-1:0];
      r.c  = full[W];
      sr   = sa + sb + $signed({{(W+1){1'b0}}, mc});
    end
    r.o = sr[W] ^ sr[W-1];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] got, req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  // Monitor / scoreboard: push on accepted bundle, pop on accepted result.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got sum=%h cout=%b ovf=%b, required no output", sum, cout, ovf);
        end else begin
          mon_e = exp_q.pop_front();
          if ({sum, cout, ovf} !== {mon_e.s, mon_e.c, mon_e.o}) begin
            n_fail++;
            $display("FAIL result: got sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     sum, cout, ovf, mon_e.s, mon_e.c, mon_e.o);
          end else begin
            $display("result ok: sum=%h cout=%b ovf=%b", sum, cout, ovf);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  // Random consumer back-pressure.
  initial begin
    or_rnd = 1'b1;
    forever begin
      @(posedge clk);
      #1 or_rnd = ($urandom_range(0, 3) != 0);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] ta, tb_, input logic tc, ts);
    int n;
    in_valid = 1'b1; a = ta; b = tb_; cin = tc; sub = ts;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 1000);
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready got 0 required 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!out_valid && c < 60) begin
      @(posedge clk);
      #1 c++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drain_empty", W'(exp_q.size()), '0);
  endtask

  task automatic run_dir(input string nm, input logic [W-1:0] ta, tb_, input logic tc, ts,
                         input logic [W-1:0] es, input logic ec, eo);
    int c;
    or_dir = 1'b0;
    send(ta, tb_, tc, ts);
    wait_valid(c);
    chk({nm, "_latency"}, W'(c), W'(WORDS));
    chk({nm, "_sum"}, sum, es);
    chk({nm, "_cout"}, W'(cout), W'(ec));
    chk({nm, "_ovf"}, W'(ovf), W'(eo));
    or_dir = 1'b1;
    drain();
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i*32 +: 32] = 32'h0;
        1:       v[i*32 +: 32] = 32'hFFFF_FFFF;
        default: v[i*32 +: 32] = $urandom;
      endcase
    end
    if ($urandom_range(0, 7) == 0) v[W-1] = ~v[W-1];
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ones, msb, x, y;
    exp_t ex;
    int c;
    ones = '1;
    msb  = {1'b1, {(W-1){1'b0}}};
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    or_dir = 1'b0; rnd_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_out_valid", W'(out_valid), '0);
    chk("reset_sum", sum, '0);
    chk("reset_cout_ovf", W'({cout, ovf}), '0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_dir("zero_cin", '0, '0, 1'b1, 1'b0, W'(1), 1'b0, 1'b0);
    run_dir("ripple", ones, W'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0);
    run_dir("borrow_word", W'(64'h1_0000_0000), W'(1), 1'b0, 1'b1, W'(64'hFFFF_FFFF), 1'b1, 1'b0);
    run_dir("sub_neg", '0, W'(1), 1'b0, 1'b1, ones, 1'b0, 1'b0);
    run_dir("ovf_add", ~msb, W'(1), 1'b0, 1'b0, msb, 1'b0, 1'b1);
    run_dir("ovf_sub", msb, W'(1), 1'b1, 1'b1, ~msb, 1'b1, 1'b1);

    // Hold the result for 10 cycles, then accept a new bundle while draining.
    x = pick(); y = pick();
    ex = model(x, y, 1'b1, 1'b0);
    or_dir = 1'b0;
    send(x, y, 1'b1, 1'b0);
    wait_valid(c);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", W'(out_valid), W'(1));
      chk("hold_in_ready", W'(in_ready), '0);
      chk("hold_sum", sum, ex.s);
    end
    @(posedge clk);
    #1;
    or_dir = 1'b1;
    in_valid = 1'b1; a = pick(); b = pick(); cin = 1'b0; sub = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("b2b_out_valid_drop", W'(out_valid), '0);
    wait_valid(c);
    chk("b2b_latency", W'(c), W'(WORDS));
    drain();

    // Reset in the middle of an operation.
    send(pick(), pick(), 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", W'(in_ready), W'(1));
    chk("midrst_out_valid", W'(out_valid), '0);
    chk("midrst_sum", sum, '0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", W'(out_valid), '0);
    end
    @(posedge clk);
    #1;
    run_dir("after_rst", ones, ones, 1'b1, 1'b0, ones, 1'b1, 1'b0);

    // Random traffic with random back-pressure.
    rnd_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drain();
    rnd_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
